cv_bank_mapper: RTL and testbench

- Parametrised successor to the fixed ColecoVision/ADAM address decoder.
- Splits the 64 KB Z80 space into NUM_WIN equal windows. Each window has a mapping code written through an I/O port, which selects one of four chip enables per window.
- Adds a registered megacart page latch, edge-detected single-shot I/O writes, and a stretched PCB-reset pulse.
- Sits between the T80 bus and the ROM/RAM/expansion chip selects in the top level.

---
 rtl/cv_mapper_pkg.sv | 28 ++
 rtl/cv_bus_oneshot.sv | 22 ++
 rtl/cv_bank_mapper.sv | 166 ++++++++++++++++
 tb/tb_cv_bank_mapper.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cv_mapper_pkg.sv
// Shared types and reset mapping tables for the ColecoVision/ADAM bank mapper.
// Window codes pick one of four chip enables: internal RAM, expansion ROM, expansion RAM, OS ROM.
package cv_mapper_pkg;

    localparam int CODE_W = 2;

    typedef enum logic [CODE_W-1:0] {
        RAM_INT = 2'b00,
        ROM_EXP = 2'b01,
        RAM_EXP = 2'b10,
        OS_ROM  = 2'b11
    } win_code_t;

    // Index 0 is the lowest window; only the first NUM_WIN entries are used.
    localparam win_code_t CONSOLE_CODE [4]  = '{OS_ROM, ROM_EXP, ROM_EXP, ROM_EXP};
    localparam win_code_t COMPUTER_CODE [4] = '{OS_ROM, RAM_INT, RAM_INT, RAM_INT};

    // Number of address bits that select a window (0 for a single window).
    function automatic int clog2_win(input int n);
        int bits;
        bits = 0;
        while ((1 << bits) < n) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/cv_bus_oneshot.sv
// Registered bus qualifier with a rising-edge fire: one pulse per strobe, however long it is held.
// Fire is combinational in the first qualifying cycle; no backpressure.
module cv_bus_oneshot (
    input  logic clk_i,
    input  logic reset_i,
    input  logic qual_i,
    output logic fire_o
);

    logic qual_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            qual_q <= 1'b0;
        end else begin
            qual_q <= qual_i;
        end
    end

    assign fire_o = qual_i & ~qual_q;

endmodule

// File: rtl/cv_bank_mapper.sv
// Windowed Z80 address decoder with I/O-programmed mapping, megacart page latch and PCB-reset stretcher.
// Chip enables are combinational; register updates land one clock after the strobe edge. Optional readback: CV_MAPPER_READBACK_EN.
module cv_bank_mapper
    import cv_mapper_pkg::*;
#(
    parameter int unsigned NUM_WIN     = 2,
    parameter int unsigned PAGE_W      = 6,
    parameter logic [7:0]  CFG_PORT    = 8'h7F,
    parameter logic [7:0]  AUX_PORT    = 8'h3F,
    parameter logic [15:0] MEGA_BASE   = 16'hFFC0,
    parameter int unsigned RESET_PULSE = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    mode_i,
    input  logic [15:0]             a_i,
    input  logic [7:0]              d_i,
    input  logic                    mreq_n_i,
    input  logic                    iorq_n_i,
    input  logic                    rd_n_i,
    input  logic                    wr_n_i,
    input  logic                    rfsh_n_i,
    input  logic [PAGE_W-1:0]       cart_pages_i,
    output logic [NUM_WIN*4-1:0]    ce_n_o,
    output logic [NUM_WIN*2-1:0]    win_code_o,
    output logic [PAGE_W-1:0]       cart_page_o,
    output logic                    eos_en_o,
    output logic                    adam_reset_pcb_n_o,
    output logic [7:0]              dout_o,
    output logic                    dout_oe_o
);

    localparam int WIN_BITS = clog2_win(NUM_WIN);
    localparam int IDX_W    = (WIN_BITS == 0) ? 1 : WIN_BITS;
    localparam int CODES_W  = NUM_WIN * CODE_W;
    localparam int CNT_W    = $clog2(RESET_PULSE + 1);
    localparam logic [IDX_W-1:0] TOP_WIN = IDX_W'(NUM_WIN - 1);

    logic [CODES_W-1:0] codes_q, codes_d, rst_codes;
    logic [PAGE_W-1:0]  cart_page_q, cart_page_d;
    logic               eos_q, eos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               io_wr_qual, io_wr_fire;
    logic               mem_rd_qual, mem_rd_fire;
    logic               cfg_wr, aux_wr, pulse_load;
    logic               mem_act, hot_hit, pulse_active;
    logic [IDX_W-1:0]   win_idx;
    logic [CODE_W-1:0]  cur_code;
    logic [NUM_WIN*4-1:0] ce_n;

    // Strobe qualifiers: an I/O write must not overlap a memory or refresh cycle.
    assign io_wr_qual  = ~iorq_n_i & ~wr_n_i & mreq_n_i & rfsh_n_i;
    assign mem_rd_qual = ~mreq_n_i & ~rd_n_i & rfsh_n_i;
    assign mem_act     = ~mreq_n_i & rfsh_n_i;

    cv_bus_oneshot u_io_wr_shot (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .qual_i  (io_wr_qual),
        .fire_o  (io_wr_fire)
    );

    cv_bus_oneshot u_mem_rd_shot (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .qual_i  (mem_rd_qual),
        .fire_o  (mem_rd_fire)
    );

    assign cfg_wr     = io_wr_fire & (a_i[7:0] == CFG_PORT);
    assign aux_wr     = io_wr_fire & (a_i[7:0] == AUX_PORT);
    assign pulse_load = aux_wr & (d_i == 8'h0F);

    generate
        if (WIN_BITS == 0) begin : g_one_win
            assign win_idx = '0;
        end else begin : g_multi_win
            assign win_idx = a_i[15 -: WIN_BITS];
        end
    endgenerate

    always_comb begin
        cur_code = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (win_idx == IDX_W'(w)) begin
                cur_code = codes_q[w*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        ce_n = '1;
        for (int w = 0; w < NUM_WIN; w++) begin
            for (int c = 0; c < 4; c++) begin
                if (mem_act && (win_idx == IDX_W'(w)) && (cur_code == CODE_W'(c))) begin
                    ce_n[w*4 + c] = 1'b0;
                end
            end
        end
    end

    // Megacart page select only applies while the top window maps expansion ROM.
    assign hot_hit = mem_rd_fire & (a_i >= MEGA_BASE) & (win_idx == TOP_WIN)
                   & (cur_code == ROM_EXP);

    always_comb begin
        rst_codes = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            rst_codes[w*CODE_W +: CODE_W] = mode_i ? CONSOLE_CODE[w] : COMPUTER_CODE[w];
        end
    end

    always_comb begin
        codes_d     = cfg_wr  ? d_i[CODES_W-1:0] : codes_q;
        eos_d       = aux_wr  ? d_i[1] : eos_q;
        cart_page_d = hot_hit ? (a_i[PAGE_W-1:0] & cart_pages_i) : cart_page_q;
        cnt_d       = cnt_q;
        if (pulse_load) begin
            cnt_d = CNT_W'(RESET_PULSE);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            codes_q     <= rst_codes;
            cart_page_q <= '0;
            eos_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            codes_q     <= codes_d;
            cart_page_q <= cart_page_d;
            eos_q       <= eos_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pulse_active       = (cnt_q != '0);
    assign ce_n_o             = ce_n;
    assign win_code_o         = codes_q;
    assign cart_page_o        = cart_page_q;
    assign eos_en_o           = eos_q;
    assign adam_reset_pcb_n_o = ~pulse_active;

`ifdef CV_MAPPER_READBACK_EN
    always_comb begin
        dout_o    = '0;
        dout_oe_o = 1'b0;
        if (!reset_i && !iorq_n_i && !rd_n_i) begin
            if (a_i[7:0] == CFG_PORT) begin
                dout_oe_o           = 1'b1;
                dout_o[CODES_W-1:0] = codes_q;
            end else if (a_i[7:0] == AUX_PORT) begin
                dout_oe_o = 1'b1;
                dout_o    = {6'b0, eos_q, pulse_active};
            end
        end
    end
`else
    assign dout_o    = '0;
    assign dout_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv_bank_mapper.sv
// Directed bench for cv_bank_mapper (NUM_WIN=2): decode table plus strobe, megacart and pulse sequences.
module tb_cv_bank_mapper;

    logic        clk_i = 1'b0;
    logic        reset_i, mode_i;
    logic [15:0] a_i;
    logic [7:0]  d_i;
    logic        mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, rfsh_n_i;
    logic [5:0]  cart_pages_i;
    logic [7:0]  ce_n_o;
    logic [3:0]  win_code_o;
    logic [5:0]  cart_page_o;
    logic        eos_en_o, adam_reset_pcb_n_o;
    logic [7:0]  dout_o;
    logic        dout_oe_o;

    int tests = 0;
    int fails = 0;

    cv_bank_mapper #(
        .NUM_WIN(2), .PAGE_W(6), .CFG_PORT(8'h7F), .AUX_PORT(8'h3F),
        .MEGA_BASE(16'hFFC0), .RESET_PULSE(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .a_i(a_i), .d_i(d_i),
        .mreq_n_i(mreq_n_i), .iorq_n_i(iorq_n_i), .rd_n_i(rd_n_i), .wr_n_i(wr_n_i),
        .rfsh_n_i(rfsh_n_i), .cart_pages_i(cart_pages_i), .ce_n_o(ce_n_o),
        .win_code_o(win_code_o), .cart_page_o(cart_page_o), .eos_en_o(eos_en_o),
        .adam_reset_pcb_n_o(adam_reset_pcb_n_o), .dout_o(dout_o), .dout_oe_o(dout_oe_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        do_wr;
        logic [7:0]  port;
        logic [7:0]  data;
        logic        mreq_n;
        logic        rfsh_n;
        logic [15:0] addr;
        logic [7:0]  exp_ce;
        logic [3:0]  exp_code;
        logic        exp_eos;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        mreq_n_i = 1'b1; iorq_n_i = 1'b1; rd_n_i = 1'b1; wr_n_i = 1'b1; rfsh_n_i = 1'b1;
    endtask

    task automatic drive_io_wr(input logic [7:0] port, input logic [7:0] data);
        bus_idle();
        a_i = {8'h00, port}; d_i = data; iorq_n_i = 1'b0; wr_n_i = 1'b0;
    endtask

    task automatic drive_mem(input logic [15:0] addr, input logic mreq_n, input logic rfsh_n);
        bus_idle();
        a_i = addr; mreq_n_i = mreq_n; rfsh_n_i = rfsh_n; rd_n_i = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk_i); drive_io_wr(port, data);
        @(negedge clk_i); bus_idle();
    endtask

    // Starts a 0x0F AUX write and counts consecutive low samples of the PCB reset.
    task automatic pulse_run(input int retrig_at, output int low);
        low = 0;
        @(negedge clk_i); drive_io_wr(8'h3F, 8'h0F);
        @(negedge clk_i); bus_idle();
        while (adam_reset_pcb_n_o == 1'b0 && low < 100) begin
            low++;
            if (low == retrig_at) drive_io_wr(8'h3F, 8'h0F);
            else bus_idle();
            @(negedge clk_i);
        end
    endtask

    initial begin
        int low;

        vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, 8'hF7, 4'h7, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h8000, 8'hDF, 4'h7, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h7FFF, 8'hF7, 4'h7, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'hFFFF, 8'hDF, 4'h7, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h9000, 8'hFF, 4'h7, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0000, 8'hFF, 4'h7, 1'b0};
        vecs[6]  = '{1'b1, 8'h7F, 8'h02, 1'b0, 1'b1, 16'h4000, 8'hFB, 4'h2, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'hC000, 8'hEF, 4'h2, 1'b0};
        vecs[8]  = '{1'b1, 8'h7F, 8'hF6, 1'b0, 1'b1, 16'h8001, 8'hDF, 4'h6, 1'b0};
        vecs[9]  = '{1'b1, 8'h3F, 8'h02, 1'b0, 1'b1, 16'h0000, 8'hFB, 4'h6, 1'b1};
        vecs[10] = '{1'b1, 8'h3F, 8'h00, 1'b0, 1'b1, 16'h0001, 8'hFB, 4'h6, 1'b0};
        vecs[11] = '{1'b1, 8'h7F, 8'h0D, 1'b0, 1'b1, 16'hA000, 8'h7F, 4'hD, 1'b0};

        reset_i = 1'b1; mode_i = 1'b1; cart_pages_i = 6'h00; a_i = '0; d_i = '0;
        bus_idle();
        repeat (2) @(negedge clk_i);
        check("rst_code", 32'(win_code_o), 32'h7);
        check("rst_cart", 32'(cart_page_o), 32'h0);
        check("rst_eos", 32'(eos_en_o), 32'h0);
        check("rst_pcb", 32'(adam_reset_pcb_n_o), 32'h1);
        check("rst_oe", 32'(dout_oe_o), 32'h0);
        reset_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) io_write(vecs[i].port, vecs[i].data);
            @(negedge clk_i);
            drive_mem(vecs[i].addr, vecs[i].mreq_n, vecs[i].rfsh_n);
            #1;
            check($sformatf("vec%0d_ce", i), 32'(ce_n_o), 32'(vecs[i].exp_ce));
            check($sformatf("vec%0d_code", i), 32'(win_code_o), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_eos", i), 32'(eos_en_o), 32'(vecs[i].exp_eos));
            @(negedge clk_i); bus_idle();
        end
        check("aux_no_pulse", 32'(adam_reset_pcb_n_o), 32'h1);

        // Write held for three clocks with data changing mid-strobe: only the first edge commits.
        @(negedge clk_i); drive_io_wr(8'h7F, 8'h02);
        @(negedge clk_i); d_i = 8'hFF;
        @(negedge clk_i);
        @(negedge clk_i); bus_idle();
        check("held_wr_code", 32'(win_code_o), 32'h2);
        @(negedge clk_i); drive_mem(16'h4000, 1'b0, 1'b1); #1;
        check("held_wr_ce", 32'(ce_n_o), 32'hFB);
        @(negedge clk_i); bus_idle();

        // Memory and I/O strobes together: no I/O action.
        @(negedge clk_i); drive_io_wr(8'h7F, 8'h0F); mreq_n_i = 1'b0;
        @(negedge clk_i); bus_idle();
        check("both_strobe_code", 32'(win_code_o), 32'h2);

        // Megacart latch.
        cart_pages_i = 6'h07;
        io_write(8'h7F, 8'h04);
        @(negedge clk_i); drive_mem(16'hFFCB, 1'b0, 1'b1); #1;
        check("mega_before_edge", 32'(cart_page_o), 32'h0);
        @(negedge clk_i);
        check("mega_latch", 32'(cart_page_o), 32'h3);
        bus_idle();
        io_write(8'h7F, 8'h00);
        @(negedge clk_i); drive_mem(16'hFFC1, 1'b0, 1'b1);
        @(negedge clk_i); bus_idle();
        check("mega_code0", 32'(cart_page_o), 32'h3);
        io_write(8'h7F, 8'h04);
        @(negedge clk_i); drive_mem(16'hFFC5, 1'b0, 1'b0); #1;
        check("rfsh_ce", 32'(ce_n_o), 32'hFF);
        @(negedge clk_i); bus_idle();
        check("rfsh_no_latch", 32'(cart_page_o), 32'h3);
        @(negedge clk_i); drive_mem(16'hFFBF, 1'b0, 1'b1);
        @(negedge clk_i); bus_idle();
        check("below_base", 32'(cart_page_o), 32'h3);
        @(negedge clk_i); drive_mem(16'hFFC2, 1'b0, 1'b1);
        @(negedge clk_i); a_i = 16'hFFC4;
        @(negedge clk_i); bus_idle();
        check("held_read_once", 32'(cart_page_o), 32'h2);
        @(negedge clk_i); drive_mem(16'hFFC4, 1'b0, 1'b1);
        @(negedge clk_i); bus_idle();
        check("second_read", 32'(cart_page_o), 32'h4);

        // PCB reset stretcher.
        pulse_run(0, low);
        check("pulse_len", 32'(low), 32'd16);
        pulse_run(10, low);
        check("retrig_len", 32'(low), 32'd26);

        @(negedge clk_i); drive_io_wr(8'h3F, 8'h0F);
        @(negedge clk_i); bus_idle();
        repeat (4) @(negedge clk_i);
        check("pulse_mid", 32'(adam_reset_pcb_n_o), 32'h0);
        mode_i = 1'b0; reset_i = 1'b1; #1;
        check("reset_mid_pulse", 32'(adam_reset_pcb_n_o), 32'h1);
        check("rst_computer_code", 32'(win_code_o), 32'h3);
        check("rst2_cart", 32'(cart_page_o), 32'h0);
        @(negedge clk_i); reset_i = 1'b0;
        @(negedge clk_i);
        check("after_reset_pcb", 32'(adam_reset_pcb_n_o), 32'h1);

`ifdef CV_MAPPER_READBACK_EN
        io_write(8'h7F, 8'h09);
        @(negedge clk_i); bus_idle(); a_i = 16'h007F; iorq_n_i = 1'b0; rd_n_i = 1'b0; #1;
        check("rb_cfg_dout", 32'(dout_o), 32'h09);
        check("rb_cfg_oe", 32'(dout_oe_o), 32'h1);
        a_i = 16'h003F; #1;
        check("rb_aux_dout", 32'(dout_o), 32'h00);
        @(negedge clk_i); bus_idle();
`else
        @(negedge clk_i); bus_idle(); a_i = 16'h007F; iorq_n_i = 1'b0; rd_n_i = 1'b0; #1;
        check("rb_off_oe", 32'(dout_oe_o), 32'h0);
        check("rb_off_dout", 32'(dout_o), 32'h0);
        @(negedge clk_i); bus_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
